// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO UART controller
package mmio_pkg;
  localparam logic [3:0] IO_NIBBLE_DEF = 4'h8;
  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_RXDATA = 3'd1;
  localparam logic [2:0] OFF_TXDATA = 3'd2;
  localparam logic [2:0] OFF_CYCLES = 3'd3;
  localparam logic [2:0] OFF_INSTRS = 3'd4;
  localparam logic [2:0] OFF_CTRCLR = 3'd5;
  localparam int ST_TX_NF = 0;
  localparam int ST_RX_NE = 1;
  localparam int ST_TX_OVF = 2;
  localparam int ST_RX_CNT = 8;
  localparam int ST_TX_CNT = 16;
  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO with combinational head and fill count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic push_ok, pop_ok;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign dout = mem[rp_q];
  assign count = cnt_q;
  // storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk)
    if (push_ok) mem[wp_q] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(push_ok);
      rp_q <= rp_q + AW'(pop_ok);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
endmodule

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: CPU-facing MMIO block with UART FIFOs, status and counters
module mmio_uart_ctrl
  import mmio_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter logic [3:0] IO_NIBBLE = IO_NIBBLE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        io_sel,
  input  logic        instr_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  localparam int TCW = $clog2(TX_DEPTH + 1);
  localparam int RCW = $clog2(RX_DEPTH + 1);
  logic [2:0] off;
  logic wr, rd, tx_wr, tx_push, tx_pop, rx_push, rx_pop, ctr_clr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [TCW-1:0] tx_cnt;
  logic [RCW-1:0] rx_cnt;
  logic [7:0] rx_dout;
  logic [31:0] status, rdata_d, cyc_q, cyc_d, ins_q, ins_d;
  logic ovf_q, ovf_d;
  logic unused_bits;
  assign unused_bits = ^{cpu_addr[27:5], cpu_addr[1:0], cpu_wdata[31:8]};
  assign io_sel = cpu_addr[31:28] == IO_NIBBLE;
  assign off = cpu_addr[4:2];
  assign wr = cpu_we && io_sel;
  assign rd = cpu_re && io_sel;
  assign tx_wr = wr && off == OFF_TXDATA;
  assign tx_push = tx_wr && !tx_full;
  assign rx_pop = rd && off == OFF_RXDATA && !rx_empty;
  assign ctr_clr = wr && off == OFF_CTRCLR;
  assign uart_tx_valid = !tx_empty;
  assign uart_rx_ready = !rx_full;
  assign tx_pop = uart_tx_valid && uart_tx_ready;
  assign rx_push = uart_rx_valid && uart_rx_ready;
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(cpu_wdata[7:0]),
    .dout(uart_tx_data), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(uart_rx_data),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );
  // status word, sticky overflow, counter next-state and load data mux
  always_comb begin
    status = '0;
    status[ST_TX_NF] = !tx_full;
    status[ST_RX_NE] = !rx_empty;
    status[ST_TX_OVF] = ovf_q;
    status[ST_RX_CNT +: 8] = sat8(32'(rx_cnt));
    status[ST_TX_CNT +: 8] = sat8(32'(tx_cnt));
    ovf_d = (tx_wr && tx_full) ? 1'b1 :
            (wr && off == OFF_STATUS && cpu_wdata[ST_TX_OVF]) ? 1'b0 : ovf_q;
    cyc_d = ctr_clr ? '0 : cyc_q + 32'd1;
    ins_d = ctr_clr ? '0 : ins_q + 32'(instr_retire);
    rdata_d = !rd ? '0 :
              off == OFF_STATUS ? status :
              off == OFF_RXDATA ? {24'h0, rx_empty ? 8'h0 : rx_dout} :
              off == OFF_CYCLES ? cyc_q :
              off == OFF_INSTRS ? ins_q : '0;
  end
  // state registers; loads return the value sampled before this edge's updates
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ovf_q <= 1'b0;
      cyc_q <= '0;
      ins_q <= '0;
      cpu_rdata <= '0;
    end else begin
      ovf_q <= ovf_d;
      cyc_q <= cyc_d;
      ins_q <= ins_d;
      cpu_rdata <= rdata_d;
    end
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb_mmio_uart_ctrl: directed plus randomized checks against a queue-based model
module tb_mmio_uart_ctrl;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam logic [31:0] A_ST = 32'h8000_0000;
  localparam logic [31:0] A_RX = 32'h8000_0004;
  localparam logic [31:0] A_TX = 32'h8000_0008;
  localparam logic [31:0] A_CY = 32'h8000_000C;
  localparam logic [31:0] A_IN = 32'h8000_0010;
  localparam logic [31:0] A_CL = 32'h8000_0014;
  logic clk = 0, rst = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic cpu_we = 0, cpu_re = 0, io_sel, instr_retire = 0;
  logic [7:0] uart_tx_data, uart_rx_data = 0;
  logic uart_tx_valid, uart_tx_ready = 0, uart_rx_valid = 0, uart_rx_ready;
  int total = 0, bad = 0;
  logic [7:0] txq[$], rxq[$];
  bit ovf;
  int unsigned cyc_m, ins_m;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  mmio_uart_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .IO_NIBBLE(4'h8)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .io_sel(io_sel), .instr_retire(instr_retire),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    ovf = 0;
    cyc_m = 0;
    ins_m = 0;
    exp_rd = 0;
  endtask

  task automatic tick();
    logic io;
    logic [2:0] off;
    bit rd, wr, txf, txe, rxf, rxe;
    #1;
    check("tx_valid", 32'(uart_tx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) check("tx_data", 32'(uart_tx_data), 32'(txq[0]));
    check("rx_ready", 32'(uart_rx_ready), 32'(rxq.size() < RXD));
    io = cpu_addr[31:28] == 4'h8;
    check("io_sel", 32'(io_sel), 32'(io));
    off = cpu_addr[4:2];
    rd = cpu_re && io;
    wr = cpu_we && io;
    txf = txq.size() == TXD;
    txe = txq.size() == 0;
    rxf = rxq.size() == RXD;
    rxe = rxq.size() == 0;
    exp_rd = 0;
    if (rd)
      case (off)
        3'd0: exp_rd = {8'h0, 8'(txq.size()), 8'(rxq.size()), 5'h0, ovf, !rxe, !txf};
        3'd1: exp_rd = rxe ? 32'h0 : 32'(rxq[0]);
        3'd3: exp_rd = cyc_m;
        3'd4: exp_rd = ins_m;
        default: exp_rd = 0;
      endcase
    if (!txe && uart_tx_ready) void'(txq.pop_front());
    if (wr && off == 3'd2) begin
      if (txf) ovf = 1;
      else txq.push_back(cpu_wdata[7:0]);
    end
    if (wr && off == 3'd0 && cpu_wdata[2]) ovf = 0;
    if (rd && off == 3'd1 && !rxe) void'(rxq.pop_front());
    if (uart_rx_valid && !rxf) rxq.push_back(uart_rx_data);
    if (wr && off == 3'd5) begin
      cyc_m = 0;
      ins_m = 0;
    end else begin
      cyc_m++;
      ins_m += 32'(instr_retire);
    end
    @(posedge clk);
    #1;
    check("rdata", cpu_rdata, exp_rd);
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_we = w;
    cpu_re = r;
    tick();
    cpu_we = 0;
    cpu_re = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_txv", 32'(uart_tx_valid), 0);
    check("rst_rxr", 32'(uart_rx_ready), 1);
    check("rst_rdata", cpu_rdata, 0);
    rst = 1;
    model_reset();
    access(A_ST, 0, 0, 1);
    check("status_rst", cpu_rdata, 32'h1);

    for (int i = 0; i < 3; i++) access(A_TX, 32'h41 + i, 1, 0);
    access(A_ST, 0, 0, 1);
    check("txcnt3", 32'(cpu_rdata[23:16]), 3);
    uart_tx_ready = 1;
    repeat (4) tick();
    uart_tx_ready = 0;
    access(A_ST, 0, 0, 1);
    check("txcnt0", 32'(cpu_rdata[23:16]), 0);

    for (int i = 0; i < TXD + 1; i++) access(A_TX, 32'h50 + i, 1, 0);
    access(A_ST, 0, 0, 1);
    check("ovf_set", 32'(cpu_rdata[2]), 1);
    check("txcnt_full", 32'(cpu_rdata[23:16]), TXD);
    access(A_ST, 32'h4, 1, 0);
    access(A_ST, 0, 0, 1);
    check("ovf_clr", 32'(cpu_rdata[2]), 0);
    check("txcnt_kept", 32'(cpu_rdata[23:16]), TXD);
    uart_tx_ready = 1;
    repeat (TXD + 1) tick();
    uart_tx_ready = 0;

    uart_rx_valid = 1;
    for (int i = 0; i < RXD + 1; i++) begin
      uart_rx_data = 8'h60 + 8'(i);
      tick();
    end
    check("rx_full_ready", 32'(uart_rx_ready), 0);
    access(A_RX, 0, 0, 1);
    check("rx_first", cpu_rdata, 32'h60);
    access(A_RX, 0, 0, 1);
    check("rx_second", cpu_rdata, 32'h61);
    uart_rx_valid = 0;
    repeat (RXD) access(A_RX, 0, 0, 1);
    access(A_RX, 0, 0, 1);
    check("rx_empty_rd", cpu_rdata, 0);
    access(A_ST, 0, 0, 1);
    check("rx_empty_cnt", 32'(cpu_rdata[15:8]), 0);
    uart_rx_valid = 1;
    uart_rx_data = 8'h99;
    access(A_RX, 0, 0, 1);
    uart_rx_valid = 0;
    check("rx_race", cpu_rdata, 0);
    access(A_RX, 0, 0, 1);
    check("rx_after_race", cpu_rdata, 32'h99);

    access(A_CL, 0, 1, 0);
    for (int i = 0; i < 100; i++) begin
      instr_retire = (i % 2 == 0) && (i < 74);
      tick();
    end
    instr_retire = 0;
    access(A_CY, 0, 0, 1);
    check("cycles", cpu_rdata, 100);
    access(A_IN, 0, 0, 1);
    check("instrs", cpu_rdata, 37);
    instr_retire = 1;
    access(A_CL, 32'h1, 1, 0);
    instr_retire = 0;
    access(A_CY, 0, 0, 1);
    check("clr_cyc", cpu_rdata, 0);
    access(A_IN, 0, 0, 1);
    check("clr_ins", cpu_rdata, 0);

    for (int i = 0; i < 3000; i++) begin
      int o;
      o = $urandom_range(0, 11);
      cpu_addr = {($urandom_range(0, 7) == 0) ? 4'h1 : 4'h8, 23'($urandom), (o > 7) ? 3'd2 : 3'(o), 2'($urandom)};
      cpu_wdata = $urandom;
      cpu_we = $urandom_range(0, 2) == 0;
      cpu_re = $urandom_range(0, 2) == 0;
      instr_retire = 1'($urandom);
      uart_tx_ready = $urandom_range(0, 9) < 3;
      uart_rx_valid = 1'($urandom);
      uart_rx_data = 8'($urandom);
      tick();
    end
    cpu_we = 0;
    cpu_re = 0;
    instr_retire = 0;
    uart_rx_valid = 0;
    access(A_CY, 0, 0, 1);

    uart_tx_ready = 1;
    repeat (TXD + 1) tick();
    uart_tx_ready = 0;
    for (int i = 0; i < 5; i++) access(A_TX, 32'hA0 + i, 1, 0);
    uart_tx_ready = 1;
    tick();
    #2;
    rst = 0;
    #1;
    check("midrst_txv", 32'(uart_tx_valid), 0);
    check("midrst_rxr", 32'(uart_rx_ready), 1);
    check("midrst_rdata", cpu_rdata, 0);
    @(posedge clk);
    #1;
    rst = 1;
    uart_tx_ready = 0;
    model_reset();
    access(A_ST, 0, 0, 1);
    check("postrst_status", cpu_rdata, 32'h1);

    uart_rx_valid = 1;
    uart_rx_data = 8'h77;
    tick();
    uart_rx_valid = 0;
    access(32'h1000_0004, 0, 0, 1);
    check("nonio_rdata", cpu_rdata, 0);
    access(A_RX, 0, 0, 1);
    check("nonio_nopop", cpu_rdata, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
